// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the seven-segment display blocks.
package disp_pkg;

    typedef enum logic {BLANK, ON} scan_state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [7:0] AN_OFF   = 8'hFF;

    // True when idx is not the rightmost digit and nibbles idx..7 are all zero.
    function automatic logic leading_zero(input logic [31:0] nibbles,
                                          input logic [2:0]  idx);
        logic z;
        z = (idx != 3'd0);
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(idx) && nibbles[4*j +: 4] != 4'h0)
                z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       bcd_mode,
    output logic [6:0] cc
);

    always_comb begin
        cc = SEG_OFF;
        if (bcd_mode && nibble > 4'd9) begin
            cc = SEG_DASH;
        end else begin
            unique case (nibble)
                4'h0: cc = 7'h40;
                4'h1: cc = 7'h79;
                4'h2: cc = 7'h24;
                4'h3: cc = 7'h30;
                4'h4: cc = 7'h19;
                4'h5: cc = 7'h12;
                4'h6: cc = 7'h02;
                4'h7: cc = 7'h78;
                4'h8: cc = 7'h00;
                4'h9: cc = 7'h10;
                4'hA: cc = 7'h08;
                4'hB: cc = 7'h03;
                4'hC: cc = 7'h46;
                4'hD: cc = 7'h21;
                4'hE: cc = 7'h06;
                4'hF: cc = 7'h0E;
            endcase
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with dead-time, blanking and frame snapshot.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DWELL = 100000,
    parameter int DEAD  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  digit_en,
    input  logic        lz_blank,
    input  logic        bcd_mode,
    output logic [6:0]  cc,
    output logic [7:0]  an,
    output logic        odp,
    output logic        frame_done
);

    localparam int PMAX = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] DWELL_END = PW'(DWELL - 1);
    localparam logic [PW-1:0] DEAD_END  = PW'(DEAD - 1);

    scan_state_t   state;
    logic [2:0]    idx;
    logic [PW-1:0] phase;

    logic [31:0]   snap_digits;
    logic [7:0]    snap_dp;
    logic [7:0]    snap_en;
    logic          snap_lz;
    logic          snap_bcd;

    logic [3:0]    nibble;
    logic [6:0]    seg;
    logic          lit;
    logic          slot_end;

    assign nibble   = snap_digits[{idx, 2'b00} +: 4];
    assign slot_end = (phase == ((state == ON) ? DWELL_END : DEAD_END));
    assign lit      = (state == ON) && snap_en[idx] &&
                      !(snap_lz && leading_zero(snap_digits, idx));

    seg7_decode u_dec (
        .nibble   (nibble),
        .bcd_mode (snap_bcd),
        .cc       (seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= BLANK;
            idx         <= 3'd0;
            phase       <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lz     <= 1'b0;
            snap_bcd    <= 1'b0;
            an          <= AN_OFF;
            cc          <= SEG_OFF;
            odp         <= 1'b1;
            frame_done  <= 1'b0;
        end else if (!enable) begin
            // Scan position is held; only the pins go dark.
            an          <= AN_OFF;
            cc          <= SEG_OFF;
            odp         <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            an          <= lit ? ~(8'd1 << idx) : AN_OFF;
            cc          <= lit ? seg : SEG_OFF;
            odp         <= lit ? ~snap_dp[idx] : 1'b1;
            frame_done  <= (state == ON) && (idx == 3'd7) && slot_end;

            if (state == BLANK && idx == 3'd0 && phase == '0) begin
                snap_digits <= digits;
                snap_dp     <= dp_mask;
                snap_en     <= digit_en;
                snap_lz     <= lz_blank;
                snap_bcd    <= bcd_mode;
            end

            if (slot_end) begin
                phase <= '0;
                if (state == BLANK) begin
                    state <= ON;
                end else begin
                    state <= BLANK;
                    idx   <= idx + 3'd1;
                end
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with DWELL=4, DEAD=2 (48-cycle frame).
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] digits = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic        bcd_mode = 1'b0;
    logic [6:0]  cc;
    logic [7:0]  an;
    logic        odp;
    logic        frame_done;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] cc;
        logic       odp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fd_last = -1;
    bit   fd_chk = 1'b0;
    bit   mon_on = 1'b0;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    disp_scan_ctrl #(.DWELL(4), .DEAD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .bcd_mode   (bcd_mode),
        .cc         (cc),
        .an         (an),
        .odp        (odp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_slot(input int i, input logic [6:0] g, input logic dp);
        exp_t e;
        e.an  = ~(8'd1 << i);
        e.cc  = g;
        e.odp = ~dp;
        repeat (4) q.push_back(e);
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        chk("frame_q_empty", q.size(), 32'd0);
    endtask

    task automatic wait_an(input logic [7:0] v, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (an === v) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every lit cycle must match the head of the scoreboard.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (mon_on) begin
            if (an !== 8'hFF) begin
                if (q.size() == 0) begin
                    chk("unexpected_lit", 32'(an), 32'hFF);
                end else begin
                    e = q.pop_front();
                    chk("scan_an", 32'(an), 32'(e.an));
                    chk("scan_cc", 32'(cc), 32'(e.cc));
                    chk("scan_odp", 32'(odp), 32'(e.odp));
                end
            end else begin
                chk("dark_cc", 32'(cc), 32'h7F);
                chk("dark_odp", 32'(odp), 32'd1);
            end
            if (frame_done === 1'b1) begin
                if (fd_chk && fd_last >= 0)
                    chk("frame_period", cyc - fd_last, 32'd48);
                fd_last = cyc;
            end
        end
    end

    initial begin
        int first;
        int dark;
        int lit;
        logic [7:0] fa;
        logic [6:0] fc;

        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            digits   = $urandom;
            dp_mask  = 8'($urandom);
            digit_en = 8'($urandom);
            lz_blank = 1'($urandom);
            bcd_mode = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset_an", 32'(an), 32'hFF);
            chk("reset_cc", 32'(cc), 32'h7F);
            chk("reset_odp", 32'(odp), 32'd1);
            chk("reset_fd", 32'(frame_done), 32'd0);
        end

        @(negedge clk);
        digits   = 32'h76543210;
        dp_mask  = 8'h00;
        digit_en = 8'hFF;
        lz_blank = 1'b0;
        bcd_mode = 1'b0;
        for (int i = 0; i < 8; i++) push_slot(i, glyph[i], 1'b0);
        fd_chk = 1'b1;
        mon_on = 1'b1;
        rst = 1'b1;

        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (first < 0 && an === 8'hFE) first = k;
        end
        chk("first_lit_cycle", first, 32'd3);

        wait_frame();
        digits   = 32'h00000305;
        lz_blank = 1'b1;
        push_slot(0, 7'h12, 1'b0);
        push_slot(1, 7'h40, 1'b0);
        push_slot(2, 7'h30, 1'b0);

        wait_frame();
        digits   = 32'h0000000C;
        lz_blank = 1'b0;
        bcd_mode = 1'b1;
        digit_en = 8'h01;
        push_slot(0, 7'h3F, 1'b0);

        wait_frame();
        bcd_mode = 1'b0;
        push_slot(0, 7'h46, 1'b0);

        wait_frame();
        digits   = 32'h11111111;
        digit_en = 8'hFF;
        dp_mask  = 8'h04;
        for (int i = 0; i < 8; i++) push_slot(i, 7'h79, i == 2);

        wait_an(8'hF7, "digit3_seen");
        digits = 32'h22222222;

        wait_frame();
        for (int i = 0; i < 8; i++) push_slot(i, 7'h24, i == 2);

        wait_an(8'hDF, "digit5_seen");
        @(negedge clk);
        fd_chk = 1'b0;
        enable = 1'b0;
        dark = 0;
        repeat (10) begin
            @(negedge clk);
            if (an === 8'hFF) dark++;
        end
        chk("pause_dark", dark, 32'd10);
        enable = 1'b1;
        lit = 0;
        repeat (3) begin
            @(negedge clk);
            if (an === 8'hDF) lit++;
        end
        chk("resume_lit", lit, 32'd2);

        wait_frame();
        for (int i = 0; i < 8; i++) push_slot(i, 7'h24, i == 2);
        @(negedge clk);
        fd_chk = 1'b1;

        wait_an(8'hEF, "digit4_seen");
        mon_on = 1'b0;
        fd_chk = 1'b0;
        q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_an", 32'(an), 32'hFF);
        chk("midreset_cc", 32'(cc), 32'h7F);
        chk("midreset_odp", 32'(odp), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        first = -1;
        fa = 8'hFF;
        fc = 7'h7F;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            @(posedge clk);
            #1;
            if (an !== 8'hFF) begin
                first = k;
                fa = an;
                fc = cc;
            end
        end
        chk("post_reset_cycle", first, 32'd3);
        chk("post_reset_an", 32'(fa), 32'hFE);
        chk("post_reset_cc", 32'(fc), 32'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexing scheduler for the 8-digit seven-segment display shared by the up/down BCD/hex counter. It gives the single shared cathode bus (`cc`, `odp`) to one anode at a time, with dead-time between digits to prevent ghosting. It also applies leading-zero blanking and BCD-invalid masking. It sits between the counter datapath (digit nibbles) and the board pins (`cc`, `an`, `odp`).

## Interface
- `DWELL`, 100000: cycles each digit is lit (1 ms at 100 MHz); legal range ≥ 1.
- `DEAD`, 100: all-anodes-off cycles before each digit; legal range ≥ 1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `enable`  in  1  1 = scan runs; 0 = scan pauses and the display goes dark.
- `digits`  in  32  eight nibbles; `digits[4i+3:4i]` is digit i, and digit 0 is the rightmost.
- `dp_mask`  in  8  bit i = 1 lights the decimal point on digit i.
- `digit_en`  in  8  bit i = 0 keeps digit i dark for its slot.
- `lz_blank`  in  1  1 = blank leading zeros.
- `bcd_mode`  in  1  1 = BCD mode; nibbles A–F show a dash.
- `cc`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  8  anodes, active-low, one-hot-low while lit.
- `odp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at the end of digit 7's slot.

## Operation
- States are `BLANK` and `ON`. A 3-bit digit index `idx` and a phase counter are sized `$clog2(max(DWELL,DEAD))`.
- `BLANK`:
  - Held for DEAD cycles with `an`=8'hFF, `cc`=7'h7F, `odp`=1.
  - Then the block moves to `ON` with the same `idx`.
- `ON`:
  - Held for DWELL cycles with `an[idx]`=0 and all other `an` bits 1.
  - Then the block moves to `BLANK`, and `idx` increments modulo 8, so 7 wraps to 0.
- Snapshot: `digits`, `dp_mask`, `digit_en`, `lz_blank` and `bcd_mode` are registered on the first `BLANK` cycle of digit 0. All eight slots of a frame use that snapshot, so there is no tearing. The snapshot reset value is all-zero.
- Slot lit condition: digit i lights only if both hold:
  - `digit_en[i]`=1.
  - It is not a leading zero. A leading zero means `lz_blank`=1, i≠0, and nibbles i..7 are all 0.
- A dark slot still takes its full DEAD+DWELL time with `an`=8'hFF. This keeps the refresh rate constant.
- Decode:
  - Hex 0–F uses the standard glyphs; 0 is 7'b1000000 and F is 7'b0001110.
  - When `bcd_mode`=1, nibbles A–F produce a dash, 7'b0111111.
  - `odp` = ~`dp_mask[idx]`, driven only while lit; otherwise 1.
- `frame_done` is 1 on the cycle after the last `ON` cycle of idx 7.

## Timing
- Reset state: `BLANK`, idx 0, phase 0, snapshot 0. Outputs are `an`=8'hFF, `cc`=7'h7F, `odp`=1, `frame_done`=0.
- All outputs are registered, giving 1 cycle from state change to pin.
- The first `an`=0 appears DEAD+1 cycles after `rst` rises with `enable`=1.
- Frame period: 8·(DEAD+DWELL) cycles; `frame_done` pulses are exactly that far apart.
- `enable`=0:
  - The state, idx and phase counter freeze.
  - On the next cycle the outputs go to the reset/dark values and `frame_done`=0.
  - When `enable` returns to 1, the block resumes the same state at the same phase count.
- Changes on `digits` mid-frame have no effect until the next digit-0 snapshot.
- Reset asserted mid-slot: on the next edge all outputs go dark and idx returns to 0. No partial-slot completion.

## Structure
- Package `disp_pkg` holds:
  - the state enum `scan_state_t {BLANK, ON}`;
  - the constants `SEG_OFF`=7'h7F, `SEG_DASH`=7'h3F, `AN_OFF`=8'hFF;
  - the function `leading_zero(nibbles, idx)`.
- Sub-module `seg7_decode` is purely combinational: nibble + `bcd_mode` → `cc`. It is reused by other display blocks.
- Scheduler FSM, counters and snapshot live in `disp_scan_ctrl`.

## Test plan
Benches use DWELL=4, DEAD=2, giving a 48-cycle frame.
- Reset: hold `rst`=0 for 5 cycles with random inputs → `an`=8'hFF, `cc`=7'h7F, `odp`=1 on every cycle. After release, `an`=8'hFE first appears on cycle 3.
- Scan order: `digits`=32'h76543210, all enabled, no blanking → `an` steps FE, FD, FB … 7F. Each is low for 4 cycles with 2 dark cycles between. `cc` for digit 0 is 7'h40. `frame_done` pulses every 48 cycles.
- Leading zeros: `digits`=32'h00000305, `lz_blank`=1 → only digits 0–2 light, with 5, 0, 3 shown. Slots 3–7 stay at `an`=8'hFF, but the frame is still 48 cycles.
- BCD mode: `digits`=32'h0000000C, `bcd_mode`=1 → digit 0 `cc`=7'h3F (dash). With `bcd_mode`=0 → 7'h46 (C).
- Snapshot/DP: change `digits` from 32'h11111111 to 32'h22222222 during digit 3 → digits 4–7 still show 1, and the next frame shows 2. `dp_mask`=8'h04 → `odp`=0 only during digit 2's lit cycles.
- Pause/reset mid-slot: `enable`=0 for 10 cycles during digit 5 ON phase 2 → dark for 10 cycles, then digit 5 resumes for exactly its 2 remaining cycles. `rst`=0 mid-slot → dark next cycle and the next lit digit is 0.
